decode_issue_queue: RTL
=======================

// Module: decode_issue_queue
// PURPOSE
// - Decoupling FIFO between the decode stage and the issue stage.
// - Buffers decoded scoreboard entries together with their control-flow flag.
// - Presents the head entry to the issue stage through a valid/ack handshake, so decode keeps running while issue stalls.
// - Cleared by the unissued-instruction flush.
// PARAMETERS
// - DEPTH  default 4  number of entries; power of two, >= 2
// PORTS
// - clk_i                  in   1      clock
// - rst_ni                 in   1      asynchronous reset, active low
// - flush_i                in   1      drop every buffered entry (flush_unissued_instr)
// - decoded_instr_i        in   $bits(scoreboard_entry_t)  decoded instruction from decode
// - decoded_instr_valid_i  in   1      decoded_instr_i valid
// - is_ctrl_flow_i         in   1      decoded instr is branch/jump
// - decoded_instr_ack_o    out  1      entry accepted this cycle
// - issue_instr_o          out  $bits(scoreboard_entry_t)  head entry to issue stage
// - issue_instr_valid_o    out  1      head entry valid
// - issue_is_ctrl_flow_o   out  1      control-flow flag of head entry
// - issue_ack_i            in   1      issue stage consumed head entry
// - count_o                out  $clog2(DEPTH+1)  current occupancy
// - full_o                 out  1      count_o == DEPTH
// - stall_decode_o         out  1      decoded_instr_valid_i & ~decoded_instr_ack_o (perf counter)
// BEHAVIOUR
// - Storage: DEPTH-entry register array; read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
//   - count register is $clog2(DEPTH+1) bits; no reset of the data array is required.
// - Reset (rst_ni=0, async): pointers=0, count=0.
//   - Outputs: issue_instr_valid_o=0, decoded_instr_ack_o=0, full_o=0, count_o=0, stall_decode_o=0.
//   - issue_instr_o and issue_is_ctrl_flow_o are don't-care while valid=0.
// - Push: decoded_instr_ack_o = decoded_instr_valid_i & ~full_o & ~flush_i.
//   - ack does not depend on issue_ack_i, so there is no combinational ready chain.
//   - On ack, {decoded_instr_i, is_ctrl_flow_i} is written at the write pointer, and the write pointer increments.
// - Pop: a pop occurs when issue_instr_valid_o & issue_ack_i & ~flush_i; the read pointer then increments.
//   - issue_ack_i while valid=0 is ignored (bench asserts it never happens).
// - Count: +1 on push only, -1 on pop only, unchanged on push+pop in the same cycle.
// - Full (count==DEPTH): ack_o=0 even if a pop occurs the same cycle; the push is accepted the next cycle.
//   - stall_decode_o=1 while valid_i is high.
// - Empty (count==0): issue_instr_valid_o=0, except in the fall-through case (see CONFIGURATION).
// - Head: issue_instr_o and issue_is_ctrl_flow_o are driven from the entry at the read pointer.
//   - Held stable while valid=1 and no pop; issue_instr_valid_o = (count!=0) & ~flush_i.
// - Latency: an entry pushed in cycle N into an empty queue is valid at issue in cycle N+1.
// - Flush: flush_i=1 in cycle N sets pointers and count to 0 in cycle N+1.
//   - In cycle N: ack_o=0 and issue_instr_valid_o=0; any push or pop is discarded.
//   - Flush has priority over push and pop.
// - Order: strict FIFO; no reordering and no entry loss except through flush.
// CONFIGURATION
// - Macro DECODE_ISSUE_QUEUE_FALLTHROUGH_EN.
// - Defined: when count==0 and decoded_instr_i is pushed, issue_instr_o = decoded_instr_i and issue_instr_valid_o=1 in the same cycle (latency 0).
//   - If issue_ack_i is also high, the entry is not written and pointers and count do not change.
//   - Otherwise the entry is stored normally.
// - Undefined: issue_instr_valid_o is driven only from storage; latency is always >= 1 cycle; no decode-to-issue combinational path.
// TESTING
// - Reset, then a push every cycle with issue_ack_i=0, DEPTH=4:
//   - ack_o high for 4 cycles, then 0; full_o=1; count_o=4; stall_decode_o=1.
// - Fill entries A,B,C,D, then hold issue_ack_i=1 for 4 cycles:
//   - issue_instr_o shows A,B,C,D in order; is_ctrl_flow flags match; valid_o falls after D.
// - Continuous push+pop for 10 cycles starting from count=2:
//   - count stays 2; pointers wrap twice; output sequence equals input sequence.
// - count=3, flush_i pulsed with push and ack in the same cycle:
//   - valid_o=0 and ack_o=0 that cycle; count_o=0 next cycle; next push appears 1 cycle later.
// - With FALLTHROUGH_EN, empty queue, push X with issue_ack_i=1:
//   - X on issue_instr_o the same cycle; count_o stays 0.
//   - Without the macro: X valid next cycle and count_o=1 meanwhile.
// - Async reset asserted mid-cycle with count=2: valid_o=0 and count_o=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/decode_issue_queue.sv
// -----------------------------------------------------------------------------
// decode_issue_queue
//   Decoupling FIFO between decode and issue. It buffers decoded scoreboard
//   entries together with their control-flow flag, and presents the head entry
//   to issue through a valid/ack handshake. This lets decode keep running while
//   issue stalls. The unissued-instruction flush empties the queue.
//
//   ENTRY_W is the width of one scoreboard entry, i.e. $bits(scoreboard_entry_t).
//   DEPTH must be a power of two and at least 2.
//
//   Optional feature: define DECODE_ISSUE_QUEUE_FALLTHROUGH_EN to enable the
//   zero-latency fall-through path. When the queue is empty, a pushed entry is
//   then presented to issue in the same cycle. Without the macro, issue is fed
//   only from storage, and there is no combinational path from decode to issue.
// -----------------------------------------------------------------------------
module decode_issue_queue #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ENTRY_W = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic [ENTRY_W-1:0]         decoded_instr_i,
  input  logic                       decoded_instr_valid_i,
  input  logic                       is_ctrl_flow_i,
  output logic                       decoded_instr_ack_o,
  output logic [ENTRY_W-1:0]         issue_instr_o,
  output logic                       issue_instr_valid_o,
  output logic                       issue_is_ctrl_flow_o,
  input  logic                       issue_ack_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       stall_decode_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  // Storage: the MSB holds the control-flow flag, the low bits hold the entry
  logic [ENTRY_W:0]   mem_q [DEPTH];

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               full_s;
  logic               empty_s;
  logic               push_s;     // decode entry accepted this cycle
  logic               valid_s;    // head presented to issue (before reset gating)
  logic               pop_s;      // issue consumed the head
  logic               bypass_s;   // fall-through entry consumed without storing
  logic               wr_en_s;
  logic               rd_en_s;
  logic [ENTRY_W:0]   head_s;
  logic [ENTRY_W:0]   in_entry_s;

  assign in_entry_s = {is_ctrl_flow_i, decoded_instr_i};

  // Occupancy flags and the push/pop/bypass handshake decisions
  always_comb begin
    full_s   = (cnt_q == CNT_W'(DEPTH));
    empty_s  = (cnt_q == {CNT_W{1'b0}});
    // ack never looks at issue_ack_i, so there is no ready chain across the queue
    push_s   = decoded_instr_valid_i & ~full_s & ~flush_i;
    valid_s  = ~empty_s & ~flush_i;
    head_s   = mem_q[rd_ptr_q];
    bypass_s = 1'b0;
`ifdef DECODE_ISSUE_QUEUE_FALLTHROUGH_EN
    if (empty_s && push_s) begin
      // An empty queue forwards the incoming entry straight to issue
      valid_s  = 1'b1;
      head_s   = in_entry_s;
      bypass_s = issue_ack_i;
    end else begin
      bypass_s = 1'b0;
    end
`endif
    pop_s    = valid_s & issue_ack_i & ~flush_i;
    // A bypassed entry is neither stored nor read back
    wr_en_s  = push_s & ~bypass_s;
    rd_en_s  = pop_s & ~bypass_s;
  end

  // Next-state for pointers and occupancy; flush has priority over push and pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      cnt_d    = {CNT_W{1'b0}};
    end else begin
      if (wr_en_s) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (rd_en_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({wr_en_s, rd_en_s})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Pointer and occupancy registers, cleared asynchronously on reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Entry storage; the contents are meaningless until written, so there is no reset
  always_ff @(posedge clk_i) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q] <= in_entry_s;
    end
  end

  // Port drive; the handshake outputs are forced low while reset is asserted
  always_comb begin
    decoded_instr_ack_o  = push_s & rst_ni;
    issue_instr_valid_o  = valid_s & rst_ni;
    issue_instr_o        = head_s[ENTRY_W-1:0];
    issue_is_ctrl_flow_o = head_s[ENTRY_W];
    count_o              = cnt_q;
    full_o               = full_s;
    stall_decode_o       = decoded_instr_valid_i & ~(push_s & rst_ni) & rst_ni;
  end

endmodule
